// File: rtl/j_rxer.sv
// Jerry UART receiver: recovers 8N1/8P1 frames from serin using a 16x baud enable
// and presents the byte with parity, framing, break and overrun status.
module j_rxer (
    input  logic       clk,
    input  logic       reset,
    input  logic       serin,
    input  logic       bx16,
    input  logic       rxpol,
    input  logic       paren,
    input  logic       even,
    input  logic       u2drd,
    output logic [7:0] dout,
    output logic       rbf,
    output logic       perr,
    output logic       ferr,
    output logic       rxbrk,
    output logic       oe,
    output logic       rxbsy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    logic       sync1;
    logic       sync2;
    logic       rxd;
    logic [3:0] scnt;
    logic [2:0] bcnt;
    logic [7:0] sh;
    logic       pacc;
    logic       pbit;
    logic       par_err;
    logic       mid_bit;

    assign rxd     = sync2 ^ rxpol;
    assign mid_bit = (scnt == 4'd15);
    assign rxbsy   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            scnt    <= 4'd0;
            bcnt    <= 3'd0;
            sh      <= 8'h00;
            pacc    <= 1'b0;
            pbit    <= 1'b0;
            par_err <= 1'b0;
            dout    <= 8'h00;
            rbf     <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            rxbrk   <= 1'b0;
            oe      <= 1'b0;
        end else begin
            sync1 <= serin;
            sync2 <= sync1;

            if (u2drd) begin
                rbf <= 1'b0;
                oe  <= 1'b0;
            end

            if (bx16) begin
                case (state)
                    IDLE: begin
                        if (!rxd) begin
                            state <= START;
                            scnt  <= 4'd0;
                        end
                    end
                    START: begin
                        scnt <= scnt + 4'd1;
                        // Seventh tick after the start edge lands in the middle of the start bit.
                        if (scnt == 4'd6) begin
                            if (!rxd) begin
                                state <= DATA;
                                scnt  <= 4'd0;
                                bcnt  <= 3'd0;
                                pacc  <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DATA: begin
                        scnt <= scnt + 4'd1;
                        if (mid_bit) begin
                            sh   <= {rxd, sh[7:1]};
                            pacc <= pacc ^ rxd;
                            if (bcnt == 3'd7) begin
                                state <= paren ? PARITY : STOP;
                            end else begin
                                bcnt <= bcnt + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        scnt <= scnt + 4'd1;
                        if (mid_bit) begin
                            pbit    <= rxd;
                            par_err <= (pacc ^ rxd) != ~even;
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        scnt <= scnt + 4'd1;
                        // Completing a frame overrides a coincident read: the new byte is unread.
                        if (mid_bit) begin
                            dout  <= sh;
                            rbf   <= 1'b1;
                            ferr  <= ~rxd;
                            perr  <= paren & par_err;
                            rxbrk <= (sh == 8'h00) & ~rxd & (~paren | ~pbit);
                            oe    <= ~u2drd & (oe | rbf);
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
